// File: rtl/pwm_timer_pkg.sv
// Shared definitions for the PWM/timer core: state encoding, ctrl register bit map, widths.
package pwm_timer_pkg;

    localparam int unsigned CW_DEF = 16;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_RUN_ENC   = 2'd1;
    localparam logic [1:0] ST_PAUSE_ENC = 2'd2;
    localparam logic [1:0] ST_DONE_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_RUN   = ST_RUN_ENC,
        ST_PAUSE = ST_PAUSE_ENC,
        ST_DONE  = ST_DONE_ENC
    } state_t;

    localparam int unsigned CTRL_MODE_BIT  = 1;
    localparam int unsigned CTRL_EN_BIT    = 2;
    localparam int unsigned CTRL_CONT_BIT  = 3;
    localparam int unsigned CTRL_SWRST_BIT = 7;

endpackage

// File: rtl/cfg_shadow.sv
// Pending-update flag and period/duty/mode shadow registers; new values land only on start or at a period boundary.
module cfg_shadow
    import pwm_timer_pkg::*;
#(
    parameter int unsigned CW = CW_DEF
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_tc_upd,
    input  logic          i_cfg_wr,
    input  logic [CW-1:0] i_period,
    input  logic [CW-1:0] i_duty,
    input  logic          i_mode,
    output logic [CW-1:0] o_period_act,
    output logic [CW-1:0] o_duty_act,
    output logic          o_mode_act,
    output logic          o_mode_chg_c
);

    logic [CW-1:0] r_period_act;
    logic [CW-1:0] r_duty_act;
    logic          r_mode_act;
    logic          r_pending;
    logic          w_valid;
    logic          w_consume;

    // A zero period is never loaded; the pending request is still consumed.
    assign w_valid      = (i_period != '0);
    assign w_consume    = i_tc_upd & r_pending;
    assign o_mode_chg_c = w_consume & w_valid & (i_mode != r_mode_act);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_period_act <= '0;
            r_duty_act   <= '0;
            r_mode_act   <= 1'b0;
            r_pending    <= 1'b0;
        end else begin
            if (i_start || (w_consume && w_valid)) begin
                r_period_act <= i_period;
                r_duty_act   <= i_duty;
                r_mode_act   <= i_mode;
            end
            if (i_start) begin
                r_pending <= 1'b0;
            end else if (w_consume) begin
                r_pending <= i_cfg_wr;
            end else if (i_cfg_wr) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign o_period_act = r_period_act;
    assign o_duty_act   = r_duty_act;
    assign o_mode_act   = r_mode_act;

endmodule

// File: rtl/counter_sequencer.sv
// Control FSM sequencing the main counter of the PWM/timer core: enable/clear, shadow loads, one-shot stop, sticky irq.
module counter_sequencer
    import pwm_timer_pkg::*;
#(
    parameter int unsigned CW         = CW_DEF,
    parameter bit          IRQ_IN_PWM = 1'b0
) (
    input  logic          slow_clk,
    input  logic          rst,
    input  logic          sw_rst,
    input  logic          ctrl_en,
    input  logic          ctrl_mode,
    input  logic          ctrl_cont,
    input  logic [CW-1:0] period_reg,
    input  logic [CW-1:0] duty_reg,
    input  logic          cfg_wr,
    input  logic          irq_clr,
    input  logic [CW-1:0] counter,
    output logic          cnt_en,
    output logic          cnt_clr,
    output logic [CW-1:0] period_act,
    output logic [CW-1:0] duty_act,
    output logic          mode_act,
    output logic          irq,
    output logic          busy
);

    state_t        r_state;
    logic          r_cnt_en;
    logic          r_cnt_clr;
    logic          r_irq;
    logic          r_busy;

    logic          w_rst;
    logic [CW-1:0] w_tc_val;
    logic          w_tc;
    logic          w_start;
    logic          w_tc_upd;
    logic          w_irq_set;
    logic          w_mode_chg;

    assign w_rst     = rst | sw_rst;
    // PWM counts 0..period-1, timer counts 0..period.
    assign w_tc_val  = mode_act ? (period_act - CW'(1)) : period_act;
    assign w_tc      = r_cnt_en & (counter == w_tc_val);
    assign w_start   = (r_state == ST_IDLE) & ctrl_en & (period_reg != '0);
    assign w_tc_upd  = (r_state == ST_RUN) & ctrl_en & w_tc;
    assign w_irq_set = w_tc & (~mode_act | IRQ_IN_PWM);

    cfg_shadow #(
        .CW (CW)
    ) u_cfg_shadow (
        .clk          (slow_clk),
        .i_rst        (w_rst),
        .i_start      (w_start),
        .i_tc_upd     (w_tc_upd),
        .i_cfg_wr     (cfg_wr),
        .i_period     (period_reg),
        .i_duty       (duty_reg),
        .i_mode       (ctrl_mode),
        .o_period_act (period_act),
        .o_duty_act   (duty_act),
        .o_mode_act   (mode_act),
        .o_mode_chg_c (w_mode_chg)
    );

    // Sequencing FSM; outputs registered alongside the state.
    always_ff @(posedge slow_clk) begin
        if (w_rst) begin
            r_state   <= ST_IDLE;
            r_cnt_en  <= 1'b0;
            r_cnt_clr <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state   <= ST_RUN;
                        r_cnt_en  <= 1'b1;
                        r_cnt_clr <= 1'b0;
                        r_busy    <= 1'b1;
                    end else begin
                        r_cnt_en  <= 1'b0;
                        r_cnt_clr <= 1'b1;
                        r_busy    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_busy <= 1'b1;
                    if (!ctrl_en) begin
                        r_state   <= ST_PAUSE;
                        r_cnt_en  <= 1'b0;
                        r_cnt_clr <= 1'b0;
                    end else if (w_tc && !mode_act && !ctrl_cont) begin
                        r_state   <= ST_DONE;
                        r_cnt_en  <= 1'b0;
                        r_cnt_clr <= 1'b1;
                    end else begin
                        r_cnt_en  <= 1'b1;
                        r_cnt_clr <= w_mode_chg;
                    end
                end
                ST_PAUSE: begin
                    r_busy    <= 1'b1;
                    r_cnt_clr <= 1'b0;
                    if (ctrl_en) begin
                        r_state  <= ST_RUN;
                        r_cnt_en <= 1'b1;
                    end else begin
                        r_cnt_en <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_cnt_en  <= 1'b0;
                    r_cnt_clr <= 1'b1;
                    if (!ctrl_en) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cnt_en  <= 1'b0;
                    r_cnt_clr <= 1'b1;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    // Sticky interrupt; a set event beats a coincident clear.
    always_ff @(posedge slow_clk) begin
        if (w_rst) begin
            r_irq <= 1'b0;
        end else if (w_irq_set) begin
            r_irq <= 1'b1;
        end else if (irq_clr) begin
            r_irq <= 1'b0;
        end
    end

    assign cnt_en  = r_cnt_en;
    assign cnt_clr = r_cnt_clr;
    assign irq     = r_irq;
    assign busy    = r_busy;

endmodule
